// File: rtl/fpu_sched_pkg.sv
// Shared types for the FPU round-robin scheduler: FPU operation encodings,
// the per-requester operation bundle and the FPU status flags.
package fpu_sched_pkg;

    localparam int PkgFpWidth = 16;
    localparam int InflightW  = 4;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [2:0] {
        FP32, FP64, FP16, FP8, FP16ALT
    } fp_format_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef struct packed {
        logic [2:0][PkgFpWidth-1:0] operands;
        operation_e                 op;
        logic                       op_mod;
        roundmode_e                 rnd_mode;
        fp_format_e                 fmt;
    } req_t;

    typedef enum logic {
        S_IDLE,
        S_OFFER
    } sched_state_e;

endpackage

// File: rtl/fpu_rr_pick.sv
// Combinational round-robin pick: first set bit of valid at or after ptr, wrapping.
// Zero latency, no handshake.
module fpu_rr_pick #(
    parameter int NumReq = 4,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] valid,
    input  logic [IdxW-1:0]   ptr,
    output logic [IdxW-1:0]   idx,
    output logic              found
);

    // Walk offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        int cand;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = NumReq - 1; off >= 0; off--) begin
            cand = (int'(ptr) + off) % NumReq;
            if (valid[cand]) begin
                found = 1'b1;
                idx   = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Shares one FPU between NumReq requesters: registered round-robin offer (one issue per 2 cycles),
// tag-routed combinational result return; offers stall on fpu_in_ready_i, results stall on the owner's rsp_ready_i.
module fpu_rr_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int NumReq      = 4,
    parameter int FpWidth     = PkgFpWidth,
    parameter int MaxInflight = 4,
    parameter int IdxW        = $clog2(NumReq),
    // One spare tag bit so a corrupted return tag beyond NumReq-1 is observable.
    parameter int TagW        = IdxW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [NumReq-1:0]    req_valid_i,
    output logic [NumReq-1:0]    req_ready_o,
    input  req_t [NumReq-1:0]    req_i,
    output logic [NumReq-1:0]    rsp_valid_o,
    input  logic [NumReq-1:0]    rsp_ready_i,
    output logic [FpWidth-1:0]   rsp_result_o,
    output status_t              rsp_status_o,
    output logic                 fpu_in_valid_o,
    input  logic                 fpu_in_ready_i,
    output req_t                 fpu_req_o,
    output logic [TagW-1:0]      fpu_tag_o,
    input  logic                 fpu_out_valid_i,
    output logic                 fpu_out_ready_o,
    input  logic [FpWidth-1:0]   fpu_result_i,
    input  status_t              fpu_status_i,
    input  logic [TagW-1:0]      fpu_tag_i,
    output logic                 fpu_flush_o,
    output logic [InflightW-1:0] inflight_o,
    output logic                 tag_err_o
);

    sched_state_e         state;
    logic [IdxW-1:0]      rr_ptr;
    logic [IdxW-1:0]      win;
    logic [InflightW-1:0] inflight;
    logic                 flush_q;
    logic                 tag_err_q;

    logic [IdxW-1:0]      pick_idx;
    logic                 pick_found;
    logic                 offer;
    logic                 in_hs;
    logic                 out_hs;
    logic                 tag_ok;
    logic [IdxW-1:0]      tag_idx;
    logic [IdxW-1:0]      next_ptr;

    fpu_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .valid (req_valid_i),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign offer    = (state == S_OFFER);
    assign in_hs    = offer && fpu_in_ready_i && !rst_i;
    assign out_hs   = fpu_out_valid_i && fpu_out_ready_o;
    assign tag_ok   = (fpu_tag_i < TagW'(NumReq));
    assign tag_idx  = fpu_tag_i[IdxW-1:0];
    assign next_ptr = (win == IdxW'(NumReq - 1)) ? '0 : win + 1'b1;

    assign fpu_in_valid_o = offer && !rst_i;
    assign fpu_req_o      = (offer && !rst_i) ? req_i[win] : '0;
    assign fpu_tag_o      = (offer && !rst_i) ? TagW'(win) : '0;
    assign fpu_flush_o    = flush_q && !rst_i;
    assign inflight_o     = rst_i ? '0 : inflight;
    assign tag_err_o      = tag_err_q && !rst_i;

    // A grant that coincides with flush is withheld; the FPU drops that op on the flush pulse.
    always_comb begin
        req_ready_o = '0;
        if (in_hs && !flush_i) begin
            req_ready_o[win] = 1'b1;
        end
    end

    // Results with an out-of-range tag have no owner and are drained unconditionally.
    always_comb begin
        rsp_valid_o     = '0;
        fpu_out_ready_o = 1'b0;
        rsp_result_o    = '0;
        rsp_status_o    = '0;
        if (!rst_i) begin
            rsp_result_o = fpu_result_i;
            rsp_status_o = fpu_status_i;
            if (tag_ok) begin
                rsp_valid_o[tag_idx] = fpu_out_valid_i;
                fpu_out_ready_o      = rsp_ready_i[tag_idx];
            end else begin
                fpu_out_ready_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            win       <= '0;
            inflight  <= '0;
            flush_q   <= 1'b0;
            tag_err_q <= 1'b0;
        end else begin
            flush_q <= flush_i;
            if (fpu_out_valid_i && !tag_ok) begin
                tag_err_q <= 1'b1;
            end
            if (flush_i) begin
                state    <= S_IDLE;
                inflight <= '0;
            end else begin
                if (in_hs && !out_hs) begin
                    inflight <= inflight + 1'b1;
                end else if (out_hs && !in_hs && inflight != '0) begin
                    inflight <= inflight - 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        if (inflight < InflightW'(MaxInflight) && pick_found) begin
                            win   <= pick_idx;
                            state <= S_OFFER;
                        end
                    end
                    S_OFFER: begin
                        if (fpu_in_ready_i) begin
                            rr_ptr <= next_ptr;
                            state  <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    a_offer_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        offer |-> req_valid_i[win]);

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        (out_hs && !in_hs) |-> (inflight != '0));

endmodule
